disp_channel_ctrl: RTL and testbench

//  Sequences the 8-channel 32-bit display multiplexer. Drives its 3-bit channel select (Test)
//  and its one-cycle channel-0 latch enable (EN). Channel changes come from a debounced

---
 rtl/disp_channel_ctrl.sv | 155 +++++++++++++++
 tb/tb_disp_channel_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/disp_channel_ctrl.sv
// Display channel sequencer: debounced/auto/override channel select,
// transition blanking and a 4-phase channel-0 write handshake.
module disp_channel_ctrl #(
    parameter int unsigned DWELL = 50_000_000,
    parameter int unsigned DBNC  = 20,
    parameter int unsigned BLANK = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_next,
    input  logic       auto_en,
    input  logic       hold,
    input  logic [2:0] sw_sel,
    input  logic       wr_req,
    output logic       wr_ack,
    output logic [2:0] Test,
    output logic       EN,
    output logic       blank
);

    localparam int unsigned DW_W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int unsigned DB_W = $clog2(DBNC + 1);
    localparam int unsigned BL_W = (BLANK > 0) ? $clog2(BLANK + 1) : 1;

    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);
    localparam logic [DB_W-1:0] DBNC_LAST  = DB_W'(DBNC - 1);
    localparam logic [BL_W-1:0] BLANK_LD   = BL_W'(BLANK);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LATCH,
        S_ACK
    } hs_state_e;

    logic            btn_db_q, btn_db_d;
    logic            btn_prev_q;
    logic [DB_W-1:0] dbnc_cnt_q, dbnc_cnt_d;
    logic [DW_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [2:0]      test_q, test_d;
    logic [BL_W-1:0] blank_cnt_q, blank_cnt_d;
    logic            blank_q, blank_d;

    logic            step_btn;
    logic            step_auto;
    logic            step;

    hs_state_e       state_q, state_d;
    logic            en_q, en_d;
    logic            ack_q, ack_d;

    // Debounce: btn_db follows btn_next only after DBNC differing samples
    always_comb begin
        btn_db_d   = btn_db_q;
        dbnc_cnt_d = '0;
        if (btn_next != btn_db_q) begin
            if (dbnc_cnt_q == DBNC_LAST) begin
                btn_db_d = btn_next;
            end else begin
                dbnc_cnt_d = dbnc_cnt_q + DB_W'(1);
            end
        end
    end

    assign step_btn  = btn_db_q & ~btn_prev_q;
    assign step_auto = auto_en & ~hold & (dwell_cnt_q == DWELL_LAST);
    assign step      = step_btn | step_auto;

    // Dwell timer, restarted by any step or when rotation is inactive
    always_comb begin
        if (!auto_en || hold || step) begin
            dwell_cnt_d = '0;
        end else begin
            dwell_cnt_d = dwell_cnt_q + DW_W'(1);
        end
    end

    // Channel select: override wins, otherwise one increment per step
    always_comb begin
        test_d = test_q;
        if (hold) begin
            test_d = sw_sel;
        end else if (step) begin
            test_d = test_q + 3'd1;
        end
    end

    // Blank window restarts on every actual change of the channel
    always_comb begin
        if (test_d != test_q) begin
            blank_cnt_d = BLANK_LD;
        end else if (blank_cnt_q != '0) begin
            blank_cnt_d = blank_cnt_q - BL_W'(1);
        end else begin
            blank_cnt_d = '0;
        end
        blank_d = (blank_cnt_d != '0);
    end

    // Channel datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_db_q    <= 1'b0;
            btn_prev_q  <= 1'b0;
            dbnc_cnt_q  <= '0;
            dwell_cnt_q <= '0;
            test_q      <= 3'd0;
            blank_cnt_q <= '0;
            blank_q     <= 1'b0;
        end else begin
            btn_db_q    <= btn_db_d;
            btn_prev_q  <= btn_db_q;
            dbnc_cnt_q  <= dbnc_cnt_d;
            dwell_cnt_q <= dwell_cnt_d;
            test_q      <= test_d;
            blank_cnt_q <= blank_cnt_d;
            blank_q     <= blank_d;
        end
    end

    // Handshake state and registered handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            en_q    <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            ack_q   <= ack_d;
        end
    end

    // Handshake next state: latch always lasts exactly one cycle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (wr_req) state_d = S_LATCH;
            S_LATCH: state_d = S_ACK;
            S_ACK:   if (!wr_req) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs decoded from the upcoming state
    always_comb begin
        en_d  = (state_d == S_LATCH);
        ack_d = (state_d == S_ACK);
    end

    assign Test   = test_q;
    assign EN     = en_q;
    assign wr_ack = ack_q;
    assign blank  = blank_q;

endmodule

// File: tb/tb_disp_channel_ctrl.sv
// Self-checking bench for disp_channel_ctrl: directed scenarios followed
// by random stimulus, all compared against a cycle-level reference model.
module tb_disp_channel_ctrl;

    localparam int DWELL = 10;
    localparam int DBNC  = 20;
    localparam int BLANK = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_next;
    logic       auto_en;
    logic       hold;
    logic [2:0] sw_sel;
    logic       wr_req;
    logic       wr_ack;
    logic [2:0] Test;
    logic       EN;
    logic       blank;

    int n_vec = 0;
    int n_err = 0;
    int en_cnt = 0;

    // reference model state
    int m_db, m_prev_db, m_run, m_dwell, m_test, m_since;
    int m_en, m_ack;

    disp_channel_ctrl #(
        .DWELL(DWELL),
        .DBNC (DBNC),
        .BLANK(BLANK)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_next(btn_next),
        .auto_en (auto_en),
        .hold    (hold),
        .sw_sel  (sw_sel),
        .wr_req  (wr_req),
        .wr_ack  (wr_ack),
        .Test    (Test),
        .EN      (EN),
        .blank   (blank)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     tag, act, exp, $time);
        end
    endtask

    // One clock edge of the reference model, using inputs seen at that edge
    task automatic model_step();
        int sb, sa, nt, ne, na;
        if (rst) begin
            m_db = 0; m_prev_db = 0; m_run = 0; m_dwell = 0;
            m_test = 0; m_since = 1000; m_en = 0; m_ack = 0;
            return;
        end
        sb = (m_db == 1 && m_prev_db == 0) ? 1 : 0;
        sa = (auto_en && !hold && m_dwell == DWELL - 1) ? 1 : 0;
        if (hold) nt = int'(sw_sel);
        else if (sb == 1 || sa == 1) nt = (m_test + 1) % 8;
        else nt = m_test;
        if (nt != m_test) m_since = 0;
        else if (m_since < 1000) m_since++;
        m_test = nt;
        if (!auto_en || hold || sb == 1 || sa == 1) m_dwell = 0;
        else m_dwell++;
        m_prev_db = m_db;
        if (int'(btn_next) != m_db) begin
            m_run++;
            if (m_run == DBNC) begin
                m_db = int'(btn_next);
                m_run = 0;
            end
        end else begin
            m_run = 0;
        end
        ne = (m_en == 0 && m_ack == 0 && wr_req) ? 1 : 0;
        na = (m_en == 1 || (m_ack == 1 && wr_req)) ? 1 : 0;
        m_en = ne;
        m_ack = na;
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            model_step();
            chk("test", 32'(Test), 32'(m_test));
            chk("blank", 32'(blank), (m_since < BLANK) ? 32'd1 : 32'd0);
            chk("en", 32'(EN), 32'(m_en));
            chk("ack", 32'(wr_ack), 32'(m_ack));
            if (EN) en_cnt++;
        end
    endtask

    initial begin
        int t0;
        rst = 1'b1; btn_next = 1'b0; auto_en = 1'b0; hold = 1'b0;
        sw_sel = 3'd0; wr_req = 1'b0;
        cyc(2);
        rst = 1'b0;
        cyc(100);
        chk("idle_test", 32'(Test), 32'd0);

        auto_en = 1'b1;
        cyc(90);
        auto_en = 1'b0;
        cyc(5);

        t0 = int'(Test);
        btn_next = 1'b1; cyc(5);
        btn_next = 1'b0; cyc(30);
        chk("glitch", 32'(Test), 32'(t0));
        btn_next = 1'b1; cyc(30);
        btn_next = 1'b0; cyc(30);
        chk("press", 32'(Test), 32'((t0 + 1) % 8));

        hold = 1'b1; sw_sel = 3'd5; cyc(10);
        btn_next = 1'b1; cyc(30);
        btn_next = 1'b0; cyc(30);
        hold = 1'b0; cyc(5);
        chk("hold", 32'(Test), 32'd5);
        btn_next = 1'b1; cyc(30);
        btn_next = 1'b0; cyc(30);
        chk("after_hold", 32'(Test), 32'd6);

        en_cnt = 0;
        wr_req = 1'b1; cyc(6);
        wr_req = 1'b0; cyc(4);
        chk("en_once", 32'(en_cnt), 32'd1);
        wr_req = 1'b1; cyc(3);
        rst = 1'b1; cyc(1);
        chk("ack_rst", 32'(wr_ack), 32'd0);
        rst = 1'b0; cyc(5);
        wr_req = 1'b0; cyc(4);
        chk("en_after_rst", 32'(en_cnt), 32'd3);

        hold = 1'b1; sw_sel = 3'd7; auto_en = 1'b1; cyc(25);
        btn_next = 1'b1; cyc(11);
        hold = 1'b0; cyc(9);
        chk("pre_coincide", 32'(Test), 32'd7);
        cyc(1);
        chk("coincide", 32'(Test), 32'd0);
        cyc(1);
        chk("coincide_one", 32'(Test), 32'd0);
        btn_next = 1'b0; auto_en = 1'b0; cyc(30);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(14) == 0) btn_next = ~btn_next;
            if ($urandom_range(49) == 0) auto_en = ~auto_en;
            if ($urandom_range(59) == 0) hold = ~hold;
            if ($urandom_range(19) == 0) sw_sel = 3'($urandom_range(7));
            if ($urandom_range(5) == 0) wr_req = ~wr_req;
            rst = ($urandom_range(399) == 0);
            cyc(1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
